// File: rtl/mac_driver_pkg.sv
// Shared definitions for the MAC datapath family: data width, FSM state
// encoding and job-mode encoding.
package mac_driver_pkg;

  localparam int MAC_DATA_WIDTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FEED  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef enum logic {
    MODE_DOT  = 1'b0,
    MODE_PROD = 1'b1
  } mode_e;

  // The drain counter runs 0,1,2; the result is captured on the third edge.
  localparam logic [1:0] DRAIN_LAST = 2'd2;

endpackage

// File: rtl/mac_driver_if.sv
// Job, operand-stream, MAC-control and result signals of the MAC driver,
// with views for the job source, the driver and the MAC datapath.
interface mac_driver_if
  import mac_driver_pkg::*;
#(
  parameter int DATA_WIDTH = MAC_DATA_WIDTH,
  parameter int LEN_WIDTH  = 8
) ();

  logic                  start;
  logic                  mode;
  logic [LEN_WIDTH-1:0]  len;
  logic                  busy;
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_a;
  logic [DATA_WIDTH-1:0] in_b;
  logic                  mac_mulsel;
  logic                  mac_addsel;
  logic [DATA_WIDTH-1:0] mac_data_0;
  logic [DATA_WIDTH-1:0] mac_data_1;
  logic [DATA_WIDTH-1:0] mac_result;
  logic                  res_valid;
  logic                  res_ready;
  logic [DATA_WIDTH-1:0] res_data;

  modport master (
    output start, mode, len, in_valid, in_a, in_b, res_ready,
    input  busy, in_ready, res_valid, res_data
  );

  modport slave (
    input  start, mode, len, in_valid, in_a, in_b, res_ready, mac_result,
    output busy, in_ready, res_valid, res_data,
           mac_mulsel, mac_addsel, mac_data_0, mac_data_1
  );

  modport mac (
    input  mac_mulsel, mac_addsel, mac_data_0, mac_data_1,
    output mac_result
  );

endinterface

// File: rtl/mac_new.sv
// Two-stage MAC datapath: a registered multiplier with product feedback
// followed by a registered accumulator.
module mac_new
  import mac_driver_pkg::*;
#(
  parameter int DATA_WIDTH = MAC_DATA_WIDTH
) (
  input  logic       clk,
  input  logic       rst_n,
  mac_driver_if.mac  bus
);

  logic [DATA_WIDTH-1:0] prod_r;
  logic [DATA_WIDTH-1:0] acc_r;
  logic [DATA_WIDTH-1:0] mult_b_s;
  logic [DATA_WIDTH-1:0] add_b_s;

  assign mult_b_s       = bus.mac_mulsel ? prod_r : bus.mac_data_1;
  assign add_b_s        = bus.mac_addsel ? acc_r : {DATA_WIDTH{1'b0}};
  assign bus.mac_result = acc_r;

  // Multiply stage then accumulate stage, both wrapping at DATA_WIDTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_r <= {DATA_WIDTH{1'b0}};
      acc_r  <= {DATA_WIDTH{1'b0}};
    end else begin
      prod_r <= bus.mac_data_0 * mult_b_s;
      acc_r  <= prod_r + add_b_s;
    end
  end

endmodule

// File: rtl/mac_driver.sv
// Job sequencer that streams operand beats into an external two-stage MAC
// and returns the dot product or running product of the beats.
module mac_driver
  import mac_driver_pkg::*;
#(
  parameter int DATA_WIDTH = MAC_DATA_WIDTH,
  parameter int LEN_WIDTH  = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  mac_driver_if.slave  bus
);

  localparam logic [DATA_WIDTH-1:0] ZERO    = {DATA_WIDTH{1'b0}};
  localparam logic [DATA_WIDTH-1:0] ONE     = {{(DATA_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [LEN_WIDTH-1:0]  LEN_ZERO = {LEN_WIDTH{1'b0}};
  localparam logic [LEN_WIDTH-1:0]  LEN_ONE  = {{(LEN_WIDTH-1){1'b0}}, 1'b1};

  state_e                state_r;
  mode_e                 mode_r;
  logic [LEN_WIDTH-1:0]  len_r;
  logic [LEN_WIDTH-1:0]  cnt_r;
  logic [1:0]            drain_r;
  logic                  beat_seen_r;
  logic                  pipe_r;
  logic                  mulsel_r;
  logic                  addsel_r;
  logic [DATA_WIDTH-1:0] data0_r;
  logic [DATA_WIDTH-1:0] data1_r;
  logic                  res_valid_r;
  logic [DATA_WIDTH-1:0] res_data_r;

  logic                  accept_s;
  logic                  active_s;
  logic [LEN_WIDTH-1:0]  cnt_inc_s;
  logic                  nxt_mulsel_s;
  logic                  nxt_addsel_s;
  logic [DATA_WIDTH-1:0] nxt_data0_s;
  logic [DATA_WIDTH-1:0] nxt_data1_s;

  assign accept_s  = (state_r == ST_FEED) && bus.in_valid;
  assign active_s  = (state_r == ST_FEED) || (state_r == ST_DRAIN);
  assign cnt_inc_s = cnt_r + LEN_ONE;

  assign bus.busy       = (state_r != ST_IDLE);
  assign bus.in_ready   = (state_r == ST_FEED);
  assign bus.mac_mulsel = mulsel_r;
  assign bus.mac_addsel = addsel_r;
  assign bus.mac_data_0 = data0_r;
  assign bus.mac_data_1 = data1_r;
  assign bus.res_valid  = res_valid_r;
  assign bus.res_data   = res_data_r;

  // Beat controls on an accept, otherwise controls that leave the MAC unchanged.
  always_comb begin
    nxt_mulsel_s = 1'b0;
    nxt_data0_s  = ZERO;
    nxt_data1_s  = ZERO;
    if (mode_r == MODE_PROD) begin
      if (accept_s) begin
        nxt_data0_s  = bus.in_a;
        nxt_data1_s  = ONE;
        nxt_mulsel_s = beat_seen_r;
      end else if (beat_seen_r) begin
        nxt_data0_s  = ONE;
        nxt_data1_s  = ONE;
        nxt_mulsel_s = 1'b1;
      end else begin
        nxt_data0_s  = ZERO;
        nxt_data1_s  = ZERO;
        nxt_mulsel_s = 1'b0;
      end
    end else begin
      if (accept_s) begin
        nxt_data0_s = bus.in_a;
        nxt_data1_s = bus.in_b;
      end else begin
        nxt_data0_s = ZERO;
        nxt_data1_s = ZERO;
      end
    end
  end

  // Accumulate only once the first product has passed the accumulator stage.
  assign nxt_addsel_s = (mode_r == MODE_DOT) && pipe_r && active_s;

  // MAC control registers; pipe_r tracks the first product one stage behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mulsel_r <= 1'b0;
      addsel_r <= 1'b0;
      data0_r  <= ZERO;
      data1_r  <= ZERO;
      pipe_r   <= 1'b0;
    end else begin
      mulsel_r <= nxt_mulsel_s;
      addsel_r <= nxt_addsel_s;
      data0_r  <= nxt_data0_s;
      data1_r  <= nxt_data1_s;
      pipe_r   <= active_s ? beat_seen_r : 1'b0;
    end
  end

  // Job FSM: beat counting, fixed-length drain, result capture and handoff.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      mode_r      <= MODE_DOT;
      len_r       <= LEN_ZERO;
      cnt_r       <= LEN_ZERO;
      drain_r     <= 2'd0;
      beat_seen_r <= 1'b0;
      res_valid_r <= 1'b0;
      res_data_r  <= ZERO;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.start) begin
            mode_r      <= mode_e'(bus.mode);
            len_r       <= bus.len;
            cnt_r       <= LEN_ZERO;
            drain_r     <= 2'd0;
            beat_seen_r <= 1'b0;
            if (bus.len == LEN_ZERO) begin
              state_r     <= ST_DONE;
              res_data_r  <= ZERO;
              res_valid_r <= 1'b1;
            end else begin
              state_r <= ST_FEED;
            end
          end
        end
        ST_FEED: begin
          if (accept_s) begin
            cnt_r       <= cnt_inc_s;
            beat_seen_r <= 1'b1;
            if (cnt_inc_s == len_r) begin
              state_r <= ST_DRAIN;
              drain_r <= 2'd0;
            end
          end
        end
        ST_DRAIN: begin
          if (drain_r == DRAIN_LAST) begin
            state_r     <= ST_DONE;
            res_data_r  <= bus.mac_result;
            res_valid_r <= 1'b1;
          end else begin
            drain_r <= drain_r + 2'd1;
          end
        end
        ST_DONE: begin
          if (bus.res_ready) begin
            state_r     <= ST_IDLE;
            res_valid_r <= 1'b0;
            beat_seen_r <= 1'b0;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          res_valid_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mac_driver.sv
// Directed and random jobs through mac_driver paired with mac_new, checked
// against an arithmetic reference of dot products and running products.
module tb_mac_driver;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  logic [15:0] a_q[$];
  logic [15:0] b_q[$];
  logic [15:0] res;

  mac_driver_if #(.DATA_WIDTH(16), .LEN_WIDTH(8)) bus ();

  mac_driver #(.DATA_WIDTH(16), .LEN_WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  mac_new #(.DATA_WIDTH(16)) mac (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: sum of a*b or product of a, reduced modulo 2^16.
  function automatic logic [15:0] model(input bit md);
    longint unsigned r;
    if (a_q.size() == 0) return 16'd0;
    r = md ? 64'd1 : 64'd0;
    for (int i = 0; i < a_q.size(); i++) begin
      if (md) r = (r * a_q[i]) % 64'd65536;
      else    r = (r + longint'(a_q[i]) * longint'(b_q[i])) % 64'd65536;
    end
    return r[15:0];
  endfunction

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_busy"},   32'(bus.busy),       32'd0);
    chk({tag, "_ready"},  32'(bus.in_ready),   32'd0);
    chk({tag, "_mulsel"}, 32'(bus.mac_mulsel), 32'd0);
    chk({tag, "_addsel"}, 32'(bus.mac_addsel), 32'd0);
    chk({tag, "_d0"},     32'(bus.mac_data_0), 32'd0);
    chk({tag, "_d1"},     32'(bus.mac_data_1), 32'd0);
    chk({tag, "_rvalid"}, 32'(bus.res_valid),  32'd0);
    chk({tag, "_rdata"},  32'(bus.res_data),   32'd0);
  endtask

  // Run one job from a_q/b_q; gap bubbles before each beat, hold cycles of
  // res_ready low in DONE, poke pulses start during FEED and DONE.
  task automatic job(input bit md, input int gap, input int hold, input bit poke,
                     output logic [15:0] result);
    int n;
    int lat;
    logic [15:0] exp_r;
    logic [15:0] held;
    n     = a_q.size();
    exp_r = model(md);
    @(negedge clk);
    bus.start = 1'b1;
    bus.mode  = md;
    bus.len   = 8'(n);
    @(negedge clk);
    bus.start = 1'b0;
    chk("busy_after_start", 32'(bus.busy), 32'd1);
    if (n == 0) begin
      chk("len0_ready",  32'(bus.in_ready),  32'd0);
      chk("len0_rvalid", 32'(bus.res_valid), 32'd1);
      chk("len0_rdata",  32'(bus.res_data),  32'd0);
    end else begin
      for (int i = 0; i < n; i++) begin
        for (int g = 0; g < gap; g++) begin
          bus.in_valid = 1'b0;
          @(negedge clk);
          chk("bubble_ready", 32'(bus.in_ready), 32'd1);
          if (!md || i == 0) begin
            chk("bubble_d0",     32'(bus.mac_data_0), 32'd0);
            chk("bubble_mulsel", 32'(bus.mac_mulsel), 32'd0);
          end else begin
            chk("bubble_d0",     32'(bus.mac_data_0), 32'd1);
            chk("bubble_mulsel", 32'(bus.mac_mulsel), 32'd1);
          end
          if (!md) chk("bubble_d1", 32'(bus.mac_data_1), 32'd0);
        end
        bus.in_valid = 1'b1;
        bus.in_a     = a_q[i];
        bus.in_b     = b_q[i];
        if (poke && i == 0) begin
          bus.start = 1'b1;
          bus.mode  = ~md;
          bus.len   = 8'd1;
        end
        @(negedge clk);
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        chk("beat_d0", 32'(bus.mac_data_0), 32'(a_q[i]));
        if (md) begin
          chk("beat_mulsel", 32'(bus.mac_mulsel), (i == 0) ? 32'd0 : 32'd1);
          chk("beat_addsel", 32'(bus.mac_addsel), 32'd0);
          if (i == 0) chk("beat_d1_first", 32'(bus.mac_data_1), 32'd1);
        end else begin
          chk("beat_d1",     32'(bus.mac_data_1), 32'(b_q[i]));
          chk("beat_mulsel", 32'(bus.mac_mulsel), 32'd0);
        end
      end
      lat = 0;
      while (!bus.res_valid && lat < 12) begin
        @(negedge clk);
        lat++;
      end
      chk("latency", 32'(lat), 32'd3);
      chk("ready_in_done", 32'(bus.in_ready), 32'd0);
    end
    chk("res_data", 32'(bus.res_data), 32'(exp_r));
    held = bus.res_data;
    bus.res_ready = 1'b0;
    for (int h = 0; h < hold; h++) begin
      if (poke && h == 1) begin
        bus.start = 1'b1;
        bus.len   = 8'd2;
      end
      @(negedge clk);
      bus.start = 1'b0;
      chk("hold_rvalid", 32'(bus.res_valid), 32'd1);
      chk("hold_rdata",  32'(bus.res_data),  32'(held));
    end
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    chk("handshake_rvalid", 32'(bus.res_valid), 32'd0);
    chk("handshake_busy",   32'(bus.busy),      32'd0);
    result = held;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    bus.start     = 1'b0;
    bus.mode      = 1'b0;
    bus.len       = 8'd0;
    bus.in_valid  = 1'b0;
    bus.in_a      = 16'd0;
    bus.in_b      = 16'd0;
    bus.res_ready = 1'b0;

    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst_n = 1'b1;

    // Dot product, back-to-back beats, then with two-cycle bubbles.
    a_q = '{16'd1, 16'd2, 16'd3};
    b_q = '{16'd4, 16'd5, 16'd6};
    job(1'b0, 0, 0, 1'b0, res);
    chk("dot_stream", 32'(res), 32'd32);
    job(1'b0, 2, 0, 1'b0, res);
    chk("dot_bubbles", 32'(res), 32'd32);

    // Running products, including a wrapping one.
    a_q = '{16'd2, 16'd3, 16'd4};
    b_q = '{16'd0, 16'd0, 16'd0};
    job(1'b1, 0, 0, 1'b0, res);
    chk("prod_3", 32'(res), 32'd24);
    a_q = '{16'd300, 16'd300};
    b_q = '{16'd0, 16'd0};
    job(1'b1, 1, 0, 1'b0, res);
    chk("prod_wrap", 32'(res), 32'd24464);

    // Empty job, then start pulses ignored in FEED and in a held DONE.
    a_q.delete();
    b_q.delete();
    job(1'b1, 0, 2, 1'b0, res);
    chk("len0", 32'(res), 32'd0);
    a_q = '{16'd10, 16'd20};
    b_q = '{16'd3, 16'd4};
    job(1'b0, 1, 5, 1'b1, res);
    chk("poke_dot", 32'(res), 32'd110);
    a_q = '{16'd7};
    b_q = '{16'd9};
    job(1'b1, 0, 0, 1'b0, res);
    chk("after_poke", 32'(res), 32'd7);

    // Reset mid-FEED after two of four beats.
    @(negedge clk);
    bus.start = 1'b1;
    bus.mode  = 1'b0;
    bus.len   = 8'd4;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.in_valid = 1'b1;
      bus.in_a     = 16'd3;
      bus.in_b     = 16'd5;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check_outputs_zero("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    a_q = '{16'd1, 16'd1};
    b_q = '{16'd7, 16'd9};
    job(1'b0, 0, 0, 1'b0, res);
    chk("after_reset", 32'(res), 32'd16);

    // Random jobs against the reference.
    for (int j = 0; j < 12; j++) begin
      int  n;
      bit  md;
      md = 1'($urandom_range(1, 0));
      n  = $urandom_range(6, 1);
      a_q.delete();
      b_q.delete();
      for (int k = 0; k < n; k++) begin
        a_q.push_back(16'($urandom));
        b_q.push_back(16'($urandom));
      end
      job(md, $urandom_range(2, 0), $urandom_range(3, 0), 1'b0, res);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mac_driver.md
MAC_DRIVER -- requirements
Module: mac_driver

Interface
REQ-001 Parameter DATA_WIDTH, default `DATA_WIDTH (16), SHALL set operand, MAC-port and result width.
REQ-002 Parameter LEN_WIDTH, default 8, SHALL set the beat-count width.
REQ-003 The block SHALL use one clock, and its reset SHALL be asynchronous and active-low. Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle job request, sampled in IDLE only.
- mode  in  1  0 = dot product (sum a*b); 1 = running product (prod a).
- len  in  LEN_WIDTH  beat count, sampled with start.
- busy  out  1  high in every state except IDLE.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  beat accepted when in_valid&in_ready at a clk edge.
- in_a  in  DATA_WIDTH  operand a.
- in_b  in  DATA_WIDTH  operand b; ignored when mode=1.
- mac_mulsel  out  1  MAC multiplier-feedback select.
- mac_addsel  out  1  MAC accumulate select.
- mac_data_0  out  DATA_WIDTH  MAC operand 0.
- mac_data_1  out  DATA_WIDTH  MAC operand 1.
- mac_result  in  DATA_WIDTH  MAC accumulator output.
- res_valid  out  1  result available.
- res_ready  in  1  result consumed when res_valid&res_ready at a clk edge.
- res_data  out  DATA_WIDTH  job result.

Function
REQ-004 The FSM SHALL have four states: IDLE, FEED, DRAIN (exactly 3 cycles), DONE.
REQ-005 IDLE SHALL go to FEED on start with len!=0, and to DONE with res_data=0 on start with len=0; mode and len are latched at this edge.
REQ-006 in_ready SHALL equal (state==FEED), combinationally from the state register.
REQ-007 FEED SHALL count accepted beats and go to DRAIN on the edge that accepts beat len.
REQ-008 All mac_* outputs SHALL be registered; on the edge accepting beat k they SHALL load that beat's controls.
REQ-009 Beat controls in mode 0: data_0=in_a, data_1=in_b, mulsel=0.
REQ-010 Beat controls in mode 1: the first beat loads data_0=in_a, data_1=1, mulsel=0; later beats load data_0=in_a, mulsel=1.
REQ-011 On any edge without an accepted beat (bubble, DRAIN, DONE, IDLE), mac_* SHALL load identity controls.
- Mode 0 identity: data_0=0, data_1=0, mulsel=0.
- Mode 1 identity after the first beat: data_0=1, mulsel=1.
- Mode 1 identity before the first beat: zeros with mulsel=0.
REQ-012 mac_addsel SHALL be registered one edge behind the operands: 0 before the first beat has reached the multiplier output, and 0 always in mode 1. In mode 0 it SHALL be 1 from the edge after the first beat's product is registered until the job ends.
REQ-013 On the third DRAIN edge (beat len accepted at edge E, capture at E+3), res_data SHALL capture mac_result, state SHALL go to DONE, and res_valid SHALL assert.
REQ-014 In DONE, res_valid and res_data SHALL hold stable until res_valid&res_ready; state then returns to IDLE and res_valid drops on that edge.
REQ-015 Arithmetic SHALL wrap modulo 2^DATA_WIDTH with no saturation or overflow flag.
REQ-016 start outside IDLE SHALL be ignored; in_valid outside FEED SHALL be ignored.

Reset
REQ-017 While rst_n=0, regardless of the current state, the block SHALL be in IDLE with every output 0, including mac_* and res_data.
REQ-018 Counters and latched mode/len SHALL clear on reset; the first job after reset SHALL be bit-exact.

Structure
REQ-019 DATA_WIDTH, the state encoding and the mode encoding SHALL live in the shared project defines/package used by the MAC and FIFO.
REQ-020 One sub-module, mac_new, SHALL be instantiated only in the bench; mac_driver itself SHALL be flat, with no sub-modules.

Verification (bench pairs mac_driver with mac_new, DATA_WIDTH=16)
REQ-021 The bench SHALL cover these scenarios:
- Mode 0, len=3, a={1,2,3}, b={4,5,6}, in_valid held high -> res_data=32, res_valid 3 edges after the last accept.
- Same job with in_valid low 2 cycles between each beat -> res_data=32, mac_out unchanged during bubbles.
- Mode 1, len=3, a={2,3,4} -> res_data=24; then a={300,300}, len=2 -> 90000 mod 65536 = 24464.
- len=0 -> DONE next edge with res_data=0, in_ready never high; start pulsed during FEED -> ignored, result unaffected.
- res_ready held low 5 cycles in DONE -> res_valid/res_data stable; a start pulsed in DONE is ignored; the next job runs after the handshake.
- rst_n pulsed low mid-FEED after 2 of 4 beats -> all outputs 0 immediately; the next job (mode 0, a={1,1}, b={7,9}) -> 16.
